// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the vehicle anti-theft alarm sequencer:
//   - state_e      : sequencer FSM states (values are visible on state_dbg)
//   - SEL_*        : parameter-select codes driven on the interval output
//   - anyDoorOpen  : helper combining both door contacts
// -----------------------------------------------------------------------------
package alarm_pkg;

  // Sequencer states. The encoding is exported on state_dbg, so it is fixed.
  typedef enum logic [2:0] {
    DISARMED   = 3'd0,
    WAIT_OPEN  = 3'd1,
    WAIT_CLOSE = 3'd2,
    ARM_DELAY  = 3'd3,
    ARMED      = 3'd4,
    TRIGGERED  = 3'd5,
    SOUND      = 3'd6
  } state_e;

  // Which stored time parameter the parameter block presents on value.
  localparam logic [1:0] SEL_ARM       = 2'b00;
  localparam logic [1:0] SEL_DRIVER    = 2'b01;
  localparam logic [1:0] SEL_PASSENGER = 2'b10;
  localparam logic [1:0] SEL_ALARM     = 2'b11;

  function automatic logic anyDoorOpen(input logic driverDoor, input logic passengerDoor);
    return driverDoor | passengerDoor;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
// Seconds countdown used by the timed states of the alarm sequencer.
// A start request arms a one-cycle load: on the following edge the counter
// takes the (by then settled) value bus. The counter then decrements on each
// one-second tick until it reaches zero; it never wraps.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-low reset
//   start          in   request a (re)load of the counter
//   value          in   TIMER_W-bit time parameter in seconds
//   one_hz_enable  in   one-cycle tick per second
//   expired        out  counter is zero and no load is outstanding
// -----------------------------------------------------------------------------
module alarm_timer #(
  parameter int TIMER_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [TIMER_W-1:0] value,
  input  logic               one_hz_enable,
  output logic               expired
);

  logic [TIMER_W-1:0] counter_q, counter_d;
  logic               loadPending_q, loadPending_d;

  // A start while a load is still pending simply keeps the load pending, so a
  // restart requested on every cycle (door held open) keeps postponing it.
  // Ticks arriving while a load is pending are discarded.
  always_comb begin
    counter_d     = counter_q;
    loadPending_d = loadPending_q;
    if (start) begin
      loadPending_d = 1'b1;
    end else if (loadPending_q) begin
      counter_d     = value;
      loadPending_d = 1'b0;
    end else if (one_hz_enable && (counter_q != '0)) begin
      counter_d = counter_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_q     <= '0;
      loadPending_q <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      loadPending_q <= loadPending_d;
    end
  end

  assign expired = (counter_q == '0) && !loadPending_q;

endmodule

// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
// Control FSM of the vehicle anti-theft system: arming, entry delay and siren
// phases, selection of the time parameter presented by the parameter block,
// and registered siren / status LED drive. Contains the countdown timer.
//
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous, active-low reset
//   ignition        in   ignition switch, 1 = on
//   driver_door     in   1 = driver door open
//   passenger_door  in   1 = passenger door open
//   reprogram       in   pulse after a parameter write, forces a re-arm
//   one_hz_enable   in   one-cycle tick per second
//   value           in   TIMER_W-bit selected time parameter
//   interval        out  parameter select (00 arm, 01 driver, 10 pass., 11 alarm)
//   siren           out  siren drive
//   status_led      out  armed indicator
//   state_dbg       out  current state encoding
//
// Build option:
//   STATUS_LED_BLINK_EN  when defined, status_led toggles on each tick while
//                        ARMED (0.5 Hz blink, starting dark on entry);
//                        otherwise it is a steady 1 while ARMED.
// -----------------------------------------------------------------------------
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int TIMER_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic               driver_door,
  input  logic               passenger_door,
  input  logic               reprogram,
  input  logic               one_hz_enable,
  input  logic [TIMER_W-1:0] value,
  output logic [1:0]         interval,
  output logic               siren,
  output logic               status_led,
  output logic [2:0]         state_dbg
);

  state_e     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic       timerStart;
  logic       expired;
  logic       doorOpen;

  assign doorOpen = anyDoorOpen(driver_door, passenger_door);

  alarm_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .start         (timerStart),
    .value         (value),
    .one_hz_enable (one_hz_enable),
    .expired       (expired)
  );

  // Next-state logic. reprogram overrides everything, then ignition (in the
  // states that honour it), then door and expiry events. Every entry into a
  // timed state, and every restart within one, raises timerStart together
  // with the new interval so the parameter block can settle before the load.
  // ARMED has no ignition exit: only a door or reprogram leaves it.
  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    timerStart = 1'b0;

    if (reprogram) begin
      state_d    = ARM_DELAY;
      interval_d = SEL_ARM;
      timerStart = 1'b1;
    end else begin
      unique case (state_q)
        DISARMED: begin
          if (!ignition) state_d = WAIT_OPEN;
        end
        WAIT_OPEN: begin
          if (ignition)         state_d = DISARMED;
          else if (driver_door) state_d = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (ignition) begin
            state_d = DISARMED;
          end else if (!doorOpen) begin
            state_d    = ARM_DELAY;
            interval_d = SEL_ARM;
            timerStart = 1'b1;
          end
        end
        ARM_DELAY: begin
          if (ignition)      state_d = DISARMED;
          else if (doorOpen) state_d = WAIT_CLOSE;
          else if (expired)  state_d = ARMED;
        end
        ARMED: begin
          if (driver_door) begin
            state_d    = TRIGGERED;
            interval_d = SEL_DRIVER;
            timerStart = 1'b1;
          end else if (passenger_door) begin
            state_d    = TRIGGERED;
            interval_d = SEL_PASSENGER;
            timerStart = 1'b1;
          end
        end
        TRIGGERED: begin
          if (ignition) begin
            state_d = DISARMED;
          end else if (expired) begin
            state_d    = SOUND;
            interval_d = SEL_ALARM;
            timerStart = 1'b1;
          end
        end
        SOUND: begin
          if (ignition) begin
            state_d = DISARMED;
          end else if (doorOpen) begin
            timerStart = 1'b1;
          end else if (expired) begin
            state_d = ARMED;
          end
        end
        default: begin
          state_d    = ARMED;
          interval_d = SEL_ARM;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they register on the same
  // edge as the state change.
  always_comb begin
    siren_d = (state_d == SOUND);
`ifdef STATUS_LED_BLINK_EN
    if ((state_d != ARMED) || (state_q != ARMED)) begin
      led_d = 1'b0;
    end else if (one_hz_enable) begin
      led_d = ~led_q;
    end else begin
      led_d = led_q;
    end
`else
    led_d = (state_d == ARMED);
`endif
  end

  // Reset lands in ARMED with every output dark and the timer idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARMED;
      interval_q <= SEL_ARM;
      siren_q    <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      siren_q    <= siren_d;
      led_q      <= led_d;
    end
  end

  assign interval   = interval_q;
  assign siren      = siren_q;
  assign status_led = led_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
// Directed, self-checking bench for alarm_sequencer in its default build
// (steady status LED). Expected values are hand-computed from the state
// sequences walked below.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

  localparam int TIMER_W = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               ignition;
  logic               driver_door;
  logic               passenger_door;
  logic               reprogram;
  logic               one_hz_enable;
  logic [TIMER_W-1:0] value;
  logic [1:0]         interval;
  logic               siren;
  logic               status_led;
  logic [2:0]         state_dbg;

  int vectors    = 0;
  int miscompares = 0;

  alarm_sequencer #(
    .TIMER_W(TIMER_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .driver_door    (driver_door),
    .passenger_door (passenger_door),
    .reprogram      (reprogram),
    .one_hz_enable  (one_hz_enable),
    .value          (value),
    .interval       (interval),
    .siren          (siren),
    .status_led     (status_led),
    .state_dbg      (state_dbg)
  );

  always #5 clock = ~clock;

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit
  // after the edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One edge with the one-second tick asserted.
  task automatic applyTick();
    one_hz_enable = 1'b1;
    applyStimulus(1);
    one_hz_enable = 1'b0;
  endtask

  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) applyTick();
  endtask

  task automatic checkField(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Checks state, interval, siren and LED; a negative expectation skips it.
  task automatic checkOutput(input string tag, input int expState, input int expInterval,
                             input int expSiren, input int expLed);
    if (expState >= 0)    checkField({tag, ".state"},    int'(state_dbg),  expState);
    if (expInterval >= 0) checkField({tag, ".interval"}, int'(interval),   expInterval);
    if (expSiren >= 0)    checkField({tag, ".siren"},    int'(siren),      expSiren);
    if (expLed >= 0)      checkField({tag, ".led"},      int'(status_led), expLed);
  endtask

  initial begin
    reset          = 1'b0;
    ignition       = 1'b0;
    driver_door    = 1'b0;
    passenger_door = 1'b0;
    reprogram      = 1'b0;
    one_hz_enable  = 1'b0;
    value          = 4'd0;

    // Reset state: ARMED, everything dark.
    applyStimulus(2);
    checkOutput("reset", 4, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("armed_idle", 4, 0, 0, 1);

    // Driver door in ARMED; first tick lands on the load edge and is dropped.
    value       = 4'd8;
    driver_door = 1'b1;
    applyStimulus(1);
    driver_door = 1'b0;
    checkOutput("drv_trig", 5, 1, 0, 0);
    applyTick();                // load edge, tick ignored
    applyTicks(7);
    applyStimulus(1);
    checkOutput("drv_7ticks", 5, 1, 0, 0);
    applyTick();                // counter reaches zero
    checkOutput("drv_8ticks", 5, 1, 0, 0);
    value = 4'd10;
    applyStimulus(1);
    checkOutput("sound_entry", 6, 3, 1, 0);

    // SOUND with 10 s; door opened at tick 5 restarts the full 10 s.
    applyStimulus(1);           // load 10
    applyTicks(5);
    driver_door = 1'b1;
    applyStimulus(1);
    driver_door = 1'b0;
    checkOutput("sound_door", 6, 3, 1, 0);
    applyStimulus(1);           // reload 10
    applyTicks(9);
    applyStimulus(1);
    checkOutput("sound_9ticks", 6, 3, 1, 0);
    applyTick();
    applyStimulus(1);
    checkOutput("sound_done", 4, -1, 0, 1);

    // Both doors together: driver wins; closing passenger alone changes nothing.
    driver_door    = 1'b1;
    passenger_door = 1'b1;
    applyStimulus(1);
    checkOutput("both_doors", 5, 1, 0, 0);
    passenger_door = 1'b0;
    applyStimulus(1);
    checkOutput("pass_closed", 5, 1, 0, 0);
    driver_door = 1'b0;

    // reprogram beats ignition in TRIGGERED.
    reprogram = 1'b1;
    ignition  = 1'b1;
    applyStimulus(1);
    reprogram = 1'b0;
    ignition  = 1'b0;
    checkOutput("reprog_win", 3, 0, 0, 0);

    // ARM_DELAY 6 s, passenger opens at tick 3, then a full 6 s after closing.
    value = 4'd6;
    applyStimulus(1);           // load 6
    applyTicks(3);
    passenger_door = 1'b1;
    applyStimulus(1);
    checkOutput("delay_door", 2, 0, 0, 0);
    passenger_door = 1'b0;
    applyStimulus(1);
    checkOutput("delay_again", 3, 0, 0, 0);
    applyStimulus(1);           // reload 6
    applyTicks(5);
    applyStimulus(1);
    checkOutput("delay_5ticks", 3, 0, 0, 0);
    applyTick();
    applyStimulus(1);
    checkOutput("delay_done", 4, 0, 0, 1);

    // Ignition path: ARM_DELAY -> DISARMED -> WAIT_OPEN -> WAIT_CLOSE -> ARM_DELAY.
    reprogram = 1'b1;
    applyStimulus(1);
    reprogram = 1'b0;
    ignition  = 1'b1;
    applyStimulus(1);
    checkOutput("ign_disarm", 0, -1, 0, 0);
    ignition = 1'b0;
    applyStimulus(1);
    checkOutput("wait_open", 1, -1, 0, 0);
    driver_door = 1'b1;
    applyStimulus(1);
    checkOutput("wait_close", 2, -1, 0, 0);
    driver_door = 1'b0;
    applyStimulus(1);
    checkOutput("rearm", 3, 0, 0, 0);
    applyStimulus(1);           // load 6
    applyTicks(6);
    applyStimulus(1);
    checkOutput("rearmed", 4, 0, 0, 1);

    // value = 0: expired on the cycle after the load.
    value          = 4'd0;
    passenger_door = 1'b1;
    applyStimulus(1);
    passenger_door = 1'b0;
    checkOutput("pass_trig", 5, 2, 0, 0);
    applyStimulus(1);           // load 0
    checkOutput("zero_load", 5, 2, 0, 0);
    applyStimulus(1);
    checkOutput("zero_sound", 6, 3, 1, 0);

    // Asynchronous reset in the middle of SOUND, effective without an edge.
    #2 reset = 1'b0;
    #1 checkOutput("async_rst", 4, 0, 0, 0);
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(3);
    checkOutput("post_rst", 4, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Control FSM of the vehicle anti-theft system. Sequences arming, entry delay and siren phases, and selects which stored time parameter (arm, driver, passenger, alarm-on) the parameter block presents on its value bus. Contains the 1 Hz-driven countdown timer that consumes that value, and drives the siren and status LED outputs.

Parameters:
TIMER_W, 4, width of the time value bus and countdown counter (seconds)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
ignition  input  1  ignition switch, 1 = on
driver_door  input  1  1 = driver door open
passenger_door  input  1  1 = passenger door open
reprogram  input  1  1-cycle pulse after a parameter write; forces a re-arm
one_hz_enable  input  1  1-cycle tick, once per second
value  input  TIMER_W  selected time parameter from the parameter block (registered there, 1-cycle lag after interval changes)
interval  output  2  parameter select: 00 arm, 01 driver, 10 passenger, 11 alarm-on
siren  output  1  siren drive
status_led  output  1  armed indicator
state_dbg  output  3  current state encoding

Behaviour:
- Reset (reset=0, async): state ARMED, interval=00, siren=0, status_led=0, counter=0, load_pending=0. All outputs are registered.
- Timer start: on every transition into a timed state, set interval on that edge and set load_pending. Next edge: counter<=value, clear load_pending. Ticks are ignored while load_pending=1.
- Timer run: counter decrements on each one_hz_enable while >0. expired = (counter==0 && !load_pending). value=N gives exactly N ticks; value=0 expires on the cycle after the load.
- States:
  - DISARMED: siren=0. ignition=0 -> WAIT_OPEN.
  - WAIT_OPEN: driver_door=1 -> WAIT_CLOSE. ignition=1 -> DISARMED.
  - WAIT_CLOSE: both doors closed -> ARM_DELAY (start timer, interval=00). ignition=1 -> DISARMED.
  - ARM_DELAY: either door open -> WAIT_CLOSE. expired -> ARMED. ignition=1 -> DISARMED.
  - ARMED: status_led on. driver_door=1 -> TRIGGERED with interval=01. Else passenger_door=1 -> TRIGGERED with interval=10. Driver wins if both doors open. Start timer on entry.
  - TRIGGERED: ignition=1 -> DISARMED. expired -> SOUND (interval=11, start timer).
  - SOUND: siren=1. Any door open restarts the timer (reload via load_pending) on every cycle it stays open. expired with doors closed -> ARMED, siren=0. ignition=1 -> DISARMED.
- Priority, highest first: reset > reprogram > ignition > door/expiry.
- reprogram in any state -> ARM_DELAY (interval=00, timer restart), siren=0.
- A tick coinciding with the load cycle is dropped.
- Re-entering the current timed state through a restart reloads the timer.
- Counter never wraps below 0.
- siren and status_led change on the same edge as the state change.

Optional Feature:
STATUS_LED_BLINK_EN
- Defined: in ARMED, status_led toggles on each one_hz_enable, giving a 0.5 Hz blink. The toggle flop is cleared to 0 on ARMED entry. status_led=0 in all other states.
- Undefined: status_led is a steady 1 in ARMED and 0 otherwise.

Decomposition:
- Package alarm_pkg holds:
  - state enum: DISARMED=0, WAIT_OPEN=1, WAIT_CLOSE=2, ARM_DELAY=3, ARMED=4, TRIGGERED=5, SOUND=6
  - interval constants: SEL_ARM, SEL_DRIVER, SEL_PASSENGER, SEL_ALARM
- One sub-module, alarm_timer:
  - handles load_pending, the counter and the expired signal
  - ports: start, value, one_hz_enable, expired

Test Plan:
- Reset low mid-SOUND -> same cycle: siren=0, state_dbg=4, interval=00. Release reset -> stays ARMED.
- ARMED, value=8, driver_door pulse -> interval=01. Timer loads 8; SOUND entered after exactly 8 ticks, siren=1.
- ARMED, both doors open on the same cycle -> interval=01 (driver priority). Close passenger only -> no state change.
- SOUND, value=10, doors closed -> after 10 ticks back to ARMED, siren=0. Open a door at tick 5 -> count restarts from 10.
- ARM_DELAY, value=6; open passenger door at tick 3 -> WAIT_CLOSE. Close it -> ARM_DELAY reloads 6, ARMED after 6 further ticks.
- TRIGGERED with reprogram and ignition=1 asserted on the same cycle -> ARM_DELAY (reprogram wins), interval=00. Also check value=0 -> expired one cycle after the load.
